instr_fetch: RTL and testbench

Instruction fetch stage for the RISC-V core: owns the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents each word with its PC to the decode stage. Decode consumes the `instr` output to drive the immediate generator and control decoder. Branches and jumps resolved downstream redirect the PC and flush any in-flight fetch.

---
 rtl/core_pkg.sv | 17 +
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core front end.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0)
//   fetch_state_e : instruction fetch FSM states
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,
        S_VALID,
        S_DROP,
        S_FAULT
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack memory
// handshake and hands each word with its PC to decode. Downstream redirects
// replace the PC and flush any in-flight fetch.
//   clk, reset_n              : clock, asynchronous active-low reset
//   mem_req, mem_addr         : registered fetch request / address (out)
//   mem_ack, mem_rdata        : memory response valid / data (in)
//   redirect_valid/_target    : one-cycle PC redirect pulse and new PC (in)
//   instr_valid, instr_ready  : decode handshake
//   instr, instr_pc           : fetched word and its address (out)
//   fetch_fault               : misaligned redirect, fetching halted (out)
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_fault
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            fault_q, fault_d;
    // A misaligned redirect seen while a request is outstanding must first
    // drain that request in S_DROP; this remembers to land in S_FAULT after.
    logic            drop_fault_q, drop_fault_d;
    logic            misaligned;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_VECTOR;
            addr_q       <= RESET_VECTOR;
            req_q        <= 1'b0;
            instr_q      <= NOP_INSTR;
            ipc_q        <= '0;
            fault_q      <= 1'b0;
            drop_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            instr_q      <= instr_d;
            ipc_q        <= ipc_d;
            fault_q      <= fault_d;
            drop_fault_q <= drop_fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        ipc_d        = ipc_q;
        fault_d      = fault_q;
        drop_fault_d = drop_fault_q;
        misaligned   = |redirect_target[1:0];

        if (redirect_valid) begin
            fault_d = misaligned;
            if (!misaligned) begin
                pc_d = redirect_target;
            end
            // req_q is low only in the first cycle out of reset, when nothing
            // has been issued yet, so there is nothing to drain then.
            if ((state_q == S_FETCH || state_q == S_DROP) && req_q && !mem_ack) begin
                state_d      = S_DROP;
                drop_fault_d = misaligned;
            end else begin
                state_d = misaligned ? S_FAULT : S_FETCH;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (req_q && mem_ack) begin
                        instr_d = mem_rdata;
                        ipc_d   = pc_q;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        state_d = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (mem_ack) begin
                        state_d = drop_fault_q ? S_FAULT : S_FETCH;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end

        // Request is registered from the next state; the address only moves
        // when (re)entering or staying in S_FETCH, so it stays frozen on the
        // outstanding address throughout S_DROP.
        req_d  = (state_d == S_FETCH) || (state_d == S_DROP);
        addr_d = (state_d == S_FETCH) ? pc_d : addr_q;
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign instr_valid = (state_q == S_VALID);
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. The bench plays instruction memory,
// tracks the expected fetch PC itself and pushes {word, pc} into a
// scoreboard whenever it acknowledges a fetch; entries are popped and
// compared when the DUT raises instr_valid.
module tb_instr_fetch;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    exp_t        sb[$];
    logic [31:0] exp_pc;
    int          n_tests;
    int          n_fail;

    instr_fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Wait for a request, check its address, optionally stall the ack,
    // then deliver data and check the word appears one cycle later.
    task automatic fetch_one(input int unsigned delay, input logic [31:0] data);
        exp_t e;
        int unsigned waited;
        waited = 0;
        while (mem_req !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        check_eq("req_seen", 32'(mem_req), 32'd1);
        check_eq("req_addr", mem_addr, exp_pc);
        for (int unsigned d = 0; d < delay; d++) begin
            mem_ack = 1'b0;
            step();
            check_eq("req_hold", 32'(mem_req), 32'd1);
            check_eq("addr_hold", mem_addr, exp_pc);
            check_eq("no_valid_wait", 32'(instr_valid), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        sb.push_back('{word: data, pc: exp_pc});
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'hxxxx_xxxx;
        exp_pc    = exp_pc + 32'd4;
        check_eq("valid_after_ack", 32'(instr_valid), 32'd1);
        check_eq("req_low_valid", 32'(mem_req), 32'd0);
        if (instr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq("instr", instr, e.word);
                check_eq("instr_pc", instr_pc, e.pc);
            end
        end
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check_eq("valid_clr_acc", 32'(instr_valid), 32'd0);
        check_eq("req_after_acc", 32'(mem_req), 32'd1);
        check_eq("addr_after_acc", mem_addr, exp_pc);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid  = 1'b1;
        redirect_target = target;
        step();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        instr_ready = 1'b0;
        exp_pc = 32'h0000_0100;

        step();
        step();
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'h0000_0013);
        check_eq("rst_pc", instr_pc, 32'd0);
        check_eq("rst_fault", 32'(fetch_fault), 32'd0);
        reset_n = 1'b1;

        // Reset vector fetch with immediate ack, then a 5-cycle decode stall.
        fetch_one(0, 32'h1111_0001);
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
            check_eq("stall_instr", instr, 32'h1111_0001);
            check_eq("stall_pc", instr_pc, 32'h0000_0100);
            check_eq("stall_req", 32'(mem_req), 32'd0);
        end
        accept();

        // Redirect while the 0x104 request is pending; ack arrives later.
        redirect(32'h0000_0200);
        for (int unsigned i = 0; i < 2; i++) begin
            check_eq("drop_req", 32'(mem_req), 32'd1);
            check_eq("drop_addr", mem_addr, 32'h0000_0104);
            check_eq("drop_valid", 32'(instr_valid), 32'd0);
            step();
        end
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        exp_pc = 32'h0000_0200;
        check_eq("drop_done_valid", 32'(instr_valid), 32'd0);
        check_eq("drop_done_req", 32'(mem_req), 32'd1);
        check_eq("drop_done_addr", mem_addr, 32'h0000_0200);
        fetch_one(2, 32'h2222_0002);

        // Misaligned redirect from S_VALID: fault, fetching halted.
        redirect(32'h0000_0202);
        for (int unsigned i = 0; i < 3; i++) begin
            check_eq("fault_set", 32'(fetch_fault), 32'd1);
            check_eq("fault_req", 32'(mem_req), 32'd0);
            check_eq("fault_valid", 32'(instr_valid), 32'd0);
            step();
        end
        redirect(32'h0000_0300);
        exp_pc = 32'h0000_0300;
        check_eq("fault_clr", 32'(fetch_fault), 32'd0);
        check_eq("recover_req", 32'(mem_req), 32'd1);
        check_eq("recover_addr", mem_addr, 32'h0000_0300);

        // Misaligned redirect while 0x300 is outstanding: drain, then fault.
        redirect(32'h0000_0306);
        check_eq("mfault_set", 32'(fetch_fault), 32'd1);
        check_eq("mfault_req", 32'(mem_req), 32'd1);
        check_eq("mfault_addr", mem_addr, 32'h0000_0300);
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        step();
        mem_ack = 1'b0;
        check_eq("mfault_req_off", 32'(mem_req), 32'd0);
        check_eq("mfault_valid", 32'(instr_valid), 32'd0);
        check_eq("mfault_hold", 32'(fetch_fault), 32'd1);

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFC);
        exp_pc = 32'hFFFF_FFFC;
        check_eq("wrap_fault_clr", 32'(fetch_fault), 32'd0);
        fetch_one(0, 32'h3333_0003);
        accept();
        check_eq("wrap_addr", mem_addr, 32'h0000_0000);

        // Redirect and instr_ready in the same cycle: word dropped.
        fetch_one(1, 32'h4444_0004);
        instr_ready = 1'b1;
        redirect(32'h0000_0400);
        instr_ready = 1'b0;
        exp_pc = 32'h0000_0400;
        check_eq("rdy_redir_valid", 32'(instr_valid), 32'd0);
        check_eq("rdy_redir_req", 32'(mem_req), 32'd1);
        check_eq("rdy_redir_addr", mem_addr, 32'h0000_0400);
        fetch_one(0, 32'h5555_0005);
        accept();

        // Redirect coinciding with the ack in S_FETCH: data discarded.
        mem_ack = 1'b1;
        mem_rdata = 32'h6666_0006;
        redirect(32'h0000_0500);
        mem_ack = 1'b0;
        exp_pc = 32'h0000_0500;
        check_eq("ack_redir_valid", 32'(instr_valid), 32'd0);
        check_eq("ack_redir_addr", mem_addr, 32'h0000_0500);
        fetch_one(0, 32'h7777_0007);
        accept();
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset while a request is outstanding.
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_req", 32'(mem_req), 32'd0);
        check_eq("async_rst_instr", instr, 32'h0000_0013);
        check_eq("async_rst_valid", 32'(instr_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
